// File: rtl/uart_pkg.sv
// Shared constants for the buffered serial-port controller.
//   UART_DATA_ADDR / UART_STAT_ADDR : CPU-visible register addresses
//   ST_*                            : bit positions inside the status word
//   TX_*                            : transmit sequencer state encodings
package uart_pkg;

    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;

    localparam int ST_TX_NOTFULL  = 0;
    localparam int ST_RX_NONEMPTY = 1;
    localparam int ST_RX_OVF      = 2;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t TX_IDLE      = 2'd0;
    localparam tx_state_t TX_LOAD      = 2'd1;
    localparam tx_state_t TX_WAIT_BUSY = 2'd2;
    localparam tx_state_t TX_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read data.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : write din at the edge (ignored when full)
//   pop, dout   : dout is the current head; pop advances it (ignored when empty)
//   full, empty : occupancy flags
//   count       : number of stored bytes
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered serial-port controller between the CPU memory stage and the
// async_transmitter / async_receiver pair.
//   clk, resetn              : clock, asynchronous active-low reset
//   mem_en, mem_we, mem_addr : CPU access qualifier, store flag, byte address
//   cpu_wdata / cpu_rdata    : store data (bits [7:0]) / combinational load data
//   stall                    : holds the pipeline on a store to a full TX FIFO
//   txd_busy, txd_start,
//   txd_data                 : transmitter handshake (start is a 1-cycle pulse)
//   rxd_data_ready, rxd_data,
//   rxd_clear                : receiver handshake (clear is a 1-cycle pulse)
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    input  logic        txd_busy,
    output logic        txd_start,
    output logic [7:0]  txd_data,
    input  logic        rxd_data_ready,
    input  logic [7:0]  rxd_data,
    output logic        rxd_clear
);

    logic hit_data;
    logic hit_stat;
    logic stat_rd;

    logic       tx_push;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       tx_empty;
    logic [$clog2(TX_DEPTH):0] tx_count;

    logic       rx_cap;
    logic       rx_push;
    logic       rx_pop;
    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_empty;
    logic [$clog2(RX_DEPTH):0] rx_count;

    logic       rx_ovf;
    tx_state_t  tx_state;

    logic unused_bits;
    assign unused_bits = ^{cpu_wdata[31:8], tx_count, rx_count};

    // Address decode and CPU-side FIFO control.
    assign hit_data = mem_en && (mem_addr == UART_DATA_ADDR);
    assign hit_stat = mem_en && (mem_addr == UART_STAT_ADDR);
    assign stat_rd  = hit_stat && !mem_we;

    // The full check deliberately ignores a same-cycle pop by the sequencer,
    // keeping stall free of any path from the transmit state machine.
    assign tx_push = hit_data && mem_we && !tx_full;
    assign stall   = hit_data && mem_we && tx_full;
    assign rx_pop  = hit_data && !mem_we && !rx_empty;

    // NOTE: every combinational output gets a default before the branches,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cpu_rdata = '0;
        if (stat_rd) begin
            cpu_rdata[ST_TX_NOTFULL]  = !tx_full;
            cpu_rdata[ST_RX_NONEMPTY] = !rx_empty;
            cpu_rdata[ST_RX_OVF]      = rx_ovf;
        end else if (rx_pop) begin
            cpu_rdata[7:0] = rx_head;
        end
    end

    // Receive capture: one capture per ready, then a clear pulse; the clear
    // cycle itself masks the still-asserted ready from being taken twice.
    assign rx_cap  = rxd_data_ready && !rxd_clear;
    assign rx_push = rx_cap && !rx_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_clear <= 1'b0;
            rx_ovf    <= 1'b0;
        end else begin
            rxd_clear <= rx_cap;
            // A drop in the same cycle as a status read must not be lost.
            if (rx_cap && rx_full) begin
                rx_ovf <= 1'b1;
            end else if (stat_rd) begin
                rx_ovf <= 1'b0;
            end
        end
    end

    // Transmit sequencer. Only LOAD pops, and LOAD is entered only with a
    // non-empty FIFO, so the pop is always honoured.
    assign tx_pop = (tx_state == TX_LOAD);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state  <= TX_IDLE;
            txd_start <= 1'b0;
            txd_data  <= 8'h00;
        end else begin
            // NOTE: the pulse default is a non-blocking assignment that the
            // LOAD branch overrides; the last scheduled update wins.
            txd_start <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    // Waiting on !txd_busy also lets a frame that was in flight
                    // across a controller reset finish undisturbed.
                    if (!tx_empty && !txd_busy) begin
                        tx_state <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    txd_data  <= tx_head;
                    txd_start <= 1'b1;
                    tx_state  <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (txd_busy) begin
                        tx_state <= TX_WAIT_DONE;
                    end
                end
                default: begin
                    if (!txd_busy) begin
                        tx_state <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (cpu_wdata[7:0]),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (rxd_data),
        .dout   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl with transmitter and receiver models.
`timescale 1ns/1ps
module tb_uart_fifo_ctrl;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        txd_busy;
    logic        txd_start;
    logic [7:0]  txd_data;
    logic        rxd_data_ready;
    logic [7:0]  rxd_data;
    logic        rxd_clear;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Scoreboards and model state.
    logic [7:0] tx_exp[$];
    logic [7:0] rx_src[$];
    int         start_log[$];
    int         tx_starts = 0;
    logic [7:0] last_tx_byte = 8'h00;
    bit         tx_hold = 1'b0;
    int         busy_cnt = 0;
    int         rx_clears = 0;
    logic       clr_prev = 1'b0;
    int         last_write_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .stall          (stall),
        .txd_busy       (txd_busy),
        .txd_start      (txd_start),
        .txd_data       (txd_data),
        .rxd_data_ready (rxd_data_ready),
        .rxd_data       (rxd_data),
        .rxd_clear      (rxd_clear)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy for 20 cycles after each start, or while held.
    initial begin
        txd_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (txd_start) begin
                check("tx_start_while_busy", {31'b0, txd_busy}, 32'h0);
                if (tx_exp.size() == 0) begin
                    check("tx_unexpected_start", tx_exp.size(), 32'd1);
                end else begin
                    check("tx_byte", {24'b0, txd_data}, {24'b0, tx_exp.pop_front()});
                end
                tx_starts++;
                start_log.push_back(cyc);
                last_tx_byte = txd_data;
                busy_cnt = 20;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            txd_busy = tx_hold || (busy_cnt != 0);
        end
    end

    // Receiver model: presents queued bytes, drops ready on each clear pulse.
    initial begin
        rxd_data_ready = 1'b0;
        rxd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rxd_clear) begin
                rx_clears++;
                check("rxd_clear_width", {31'b0, clr_prev}, 32'h0);
                rxd_data_ready = 1'b0;
            end else if (!rxd_data_ready && rx_src.size() != 0) begin
                rxd_data = rx_src.pop_front();
                rxd_data_ready = 1'b1;
            end
            clr_prev = rxd_clear;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_idle();
        mem_en = 1'b0;
        mem_we = 1'b0;
        mem_addr = 32'h0;
        cpu_wdata = 32'h0;
    endtask

    // Called just after a negedge; leaves the request asserted at the next one.
    task automatic cpu_write(input logic [7:0] b);
        int guard;
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_addr = UART_DATA_ADDR;
        cpu_wdata = {24'h5A5A5A, b};
        last_write_cyc = cyc;
        #1;
        guard = 0;
        while (stall && guard < 2000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (stall) check("write_stall_timeout", {31'b0, stall}, 32'h0);
        tx_exp.push_back(b);
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        mem_en = 1'b1;
        mem_we = 1'b0;
        mem_addr = addr;
        cpu_wdata = 32'h0;
        #1;
        check(tag, cpu_rdata, exp);
        @(negedge clk);
        bus_idle();
    endtask

    initial begin
        int guard;
        int s0;
        int c0;
        int w0;
        logic [7:0] b17;

        bus_idle();
        resetn = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset_txd_start", {31'b0, txd_start}, 32'h0);
        check("reset_rxd_clear", {31'b0, rxd_clear}, 32'h0);
        check("reset_txd_data", {24'b0, txd_data}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check("idle_stall", {31'b0, stall}, 32'h0);
        check("idle_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        cpu_read(UART_STAT_ADDR, 32'h1, "reset_status");

        // Three back-to-back writes to an idle transmitter.
        start_log.delete();
        s0 = tx_starts;
        cpu_write(8'h41);
        w0 = last_write_cyc;
        cpu_write(8'h42);
        cpu_write(8'h43);
        bus_idle();
        guard = 0;
        while ((tx_starts < s0 + 3 || txd_busy) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("tx3_start_count", tx_starts - s0, 32'd3);
        if (start_log.size() >= 3) begin
            check("tx_first_latency", start_log[0] - w0, 32'd3);
            check("tx_gap_1", start_log[1] - start_log[0], 32'd23);
            check("tx_gap_2", start_log[2] - start_log[1], 32'd23);
        end else begin
            check("tx3_log_size", start_log.size(), 32'd3);
        end
        repeat (3) @(negedge clk);

        // Fill the TX FIFO with the transmitter held busy.
        @(posedge clk);
        #1 tx_hold = 1'b1;
        @(negedge clk);
        s0 = tx_starts;
        for (int i = 0; i < 16; i++) begin
            cpu_write(8'h80 + 8'(i));
        end
        b17 = 8'h90;
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_addr = UART_DATA_ADDR;
        cpu_wdata = {24'h5A5A5A, b17};
        #1;
        check("stall_on_17th", {31'b0, stall}, 32'h1);
        @(posedge clk);
        #1 tx_hold = 1'b0;
        @(negedge clk);
        #1;
        check("stall_busy_fall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        #1;
        check("stall_in_load", {31'b0, stall}, 32'h1);
        @(negedge clk);
        #1;
        check("stall_release", {31'b0, stall}, 32'h0);
        tx_exp.push_back(b17);
        @(negedge clk);
        bus_idle();
        guard = 0;
        while ((tx_starts < s0 + 17 || txd_busy) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("fill_start_count", tx_starts - s0, 32'd17);
        check("fill_last_byte", {24'b0, last_tx_byte}, {24'b0, b17});
        repeat (3) @(negedge clk);

        // Two received bytes.
        c0 = rx_clears;
        rx_src.push_back(8'h55);
        rx_src.push_back(8'hAA);
        guard = 0;
        while (rx_clears < c0 + 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("rx2_clear_count", rx_clears - c0, 32'd2);
        cpu_read(UART_STAT_ADDR, 32'h3, "rx2_status");
        cpu_read(UART_DATA_ADDR, 32'h55, "rx2_read0");
        cpu_read(UART_DATA_ADDR, 32'hAA, "rx2_read1");
        mem_en = 1'b1;
        mem_we = 1'b0;
        mem_addr = UART_DATA_ADDR;
        #1;
        check("rx_empty_read", cpu_rdata, 32'h0);
        check("rx_empty_no_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        bus_idle();

        // Overflow: 17 bytes with no reads in between.
        c0 = rx_clears;
        for (int i = 0; i < 17; i++) begin
            rx_src.push_back(8'hC0 + 8'(i));
        end
        guard = 0;
        while (rx_clears < c0 + 17 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("ovf_clear_count", rx_clears - c0, 32'd17);
        cpu_read(UART_STAT_ADDR, 32'h7, "ovf_status_set");
        cpu_read(UART_STAT_ADDR, 32'h3, "ovf_status_cleared");
        for (int i = 0; i < 16; i++) begin
            cpu_read(UART_DATA_ADDR, 32'hC0 + i, "ovf_read");
        end
        cpu_read(UART_STAT_ADDR, 32'h1, "ovf_drained_status");

        // Reset while the transmitter is mid-frame with 3 bytes queued.
        s0 = tx_starts;
        cpu_write(8'h11);
        cpu_write(8'h12);
        cpu_write(8'h13);
        cpu_write(8'h14);
        bus_idle();
        guard = 0;
        while (tx_starts < s0 + 1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("mid_first_start", tx_starts - s0, 32'd1);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        tx_exp.delete();
        repeat (2) @(negedge clk);
        check("mid_reset_txd_start", {31'b0, txd_start}, 32'h0);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("no_start_after_reset", tx_starts - s0, 32'd1);
        cpu_write(8'h99);
        w0 = last_write_cyc;
        bus_idle();
        guard = 0;
        while (tx_starts < s0 + 2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("post_reset_start", tx_starts - s0, 32'd2);
        check("post_reset_latency", start_log[start_log.size() - 1] - w0, 32'd3);
        check("post_reset_byte", {24'b0, last_tx_byte}, 32'h99);
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
